// File: rtl/audio_snapshot_drain_if.sv
// Sample input, trigger and drain stream bundle for audio_snapshot_drain.
// The slave modport is the block side; the master modport is the producer/consumer side.
interface audio_snapshot_drain_if;
  logic        audio_valid_in;
  logic [15:0] audio_in;
  logic        trigger_in;
  logic        drain_ready_in;
  logic        drain_valid_out;
  logic [15:0] drain_data_out;
  logic        drain_last_out;
  logic        busy_out;
  logic        done_out;

  modport slave (
    input  audio_valid_in, audio_in, trigger_in, drain_ready_in,
    output drain_valid_out, drain_data_out, drain_last_out, busy_out, done_out
  );

  modport master (
    output audio_valid_in, audio_in, trigger_in, drain_ready_in,
    input  drain_valid_out, drain_data_out, drain_last_out, busy_out, done_out
  );
endinterface

// File: rtl/audio_snapshot_drain.sv
// Freezes SNAP_LEN audio samples into block RAM on trigger, then streams them
// out in capture order over valid/ready. RAM reads take two cycles (RAM +
// output register); a 4-entry prefetch FIFO with credit accounting hides that
// so a consumer holding ready high sees one word per cycle.
module audio_snapshot_drain #(
  parameter int SNAP_LEN   = 4096,
  parameter int ADDR_WIDTH = 12
) (
  input logic                   clk_in,
  input logic                   rst_in,
  audio_snapshot_drain_if.slave bus
);
  localparam int FIFO_DEPTH = 4;
  localparam int RD_LAT     = 2;
  localparam logic [ADDR_WIDTH:0] LEN  = (ADDR_WIDTH+1)'(SNAP_LEN);
  localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH+1)'(SNAP_LEN-1);

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;
  state_t state, state_nxt;

  logic [ADDR_WIDTH:0] wr_cnt, rd_cnt, out_cnt;
  logic [15:0]         mem [2**ADDR_WIDTH];
  logic [15:0]         rd_q1, rd_q2;
  logic [RD_LAT-1:0]   vld_pipe;

  logic [15:0] fifo_data [FIFO_DEPTH];
  logic [1:0]  wptr, rptr;
  logic [2:0]  fcnt;

  logic start, wr_en, capture_done, rd_issue, push, pop, drain_valid, last_hs, done_q;

  assign start        = (state == IDLE) && bus.trigger_in;
  assign wr_en        = (state == CAPTURE) && bus.audio_valid_in;
  assign capture_done = wr_en && (wr_cnt == LAST);
  // Only issue a read when the FIFO is guaranteed room for it and everything in flight.
  assign rd_issue     = (state == DRAIN) && (rd_cnt != LEN) &&
                        (({1'b0, fcnt} + {3'b0, vld_pipe[0]} + {3'b0, vld_pipe[1]}) < 4'(FIFO_DEPTH));
  assign push         = vld_pipe[RD_LAT-1];
  assign drain_valid  = (state == DRAIN) && (fcnt != 3'd0);
  assign pop          = drain_valid && bus.drain_ready_in;
  assign last_hs      = pop && (out_cnt == LAST);

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; triggers outside IDLE are simply dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.trigger_in) state_nxt = CAPTURE;
      CAPTURE: if (capture_done)   state_nxt = DRAIN;
      DRAIN:   if (last_hs)        state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs; data/last are masked so nothing leaks while no word is offered.
  always_comb begin
    bus.busy_out        = (state != IDLE);
    bus.drain_valid_out = drain_valid;
    bus.drain_data_out  = drain_valid ? fifo_data[rptr] : 16'h0000;
    bus.drain_last_out  = drain_valid && (out_cnt == LAST);
    bus.done_out        = done_q;
  end

  // Write, read-issue and handshake counters; all restart from 0 on a new trigger.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      out_cnt <= '0;
    end else if (start) begin
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      out_cnt <= '0;
    end else begin
      if (wr_en)    wr_cnt  <= wr_cnt + 1'b1;
      if (rd_issue) rd_cnt  <= rd_cnt + 1'b1;
      if (pop)      out_cnt <= out_cnt + 1'b1;
    end
  end

  // Snapshot RAM: write port plus registered read with enabled output register.
  always_ff @(posedge clk_in) begin
    if (wr_en)    mem[wr_cnt[ADDR_WIDTH-1:0]] <= bus.audio_in;
    if (rd_issue) rd_q1 <= mem[rd_cnt[ADDR_WIDTH-1:0]];
    rd_q2 <= rd_q1;
  end

  // Read-valid shift register tracking words moving through the RAM pipeline.
  always_ff @(posedge clk_in) begin
    if (rst_in) vld_pipe <= '0;
    else        vld_pipe <= {vld_pipe[RD_LAT-2:0], rd_issue};
  end

  // Prefetch FIFO pointers and occupancy.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wptr <= '0;
      rptr <= '0;
      fcnt <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      fcnt <= fcnt + 3'(push) - 3'(pop);
    end
  end

  // Prefetch FIFO storage.
  always_ff @(posedge clk_in) begin
    if (push) fifo_data[wptr] <= rd_q2;
  end

  // One-cycle done pulse following the final handshake.
  always_ff @(posedge clk_in) begin
    if (rst_in) done_q <= 1'b0;
    else        done_q <= last_hs;
  end
endmodule

// File: tb/tb_audio_snapshot_drain.sv
// Scoreboard bench: capture tasks push expected words, per-DUT monitors pop and
// compare on every handshake and check that stalled words hold steady.
module tb_audio_snapshot_drain;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  logic        audio_valid = 1'b0;
  logic [15:0] audio       = 16'h0;
  logic        trig8 = 1'b0, trig16 = 1'b0;
  logic        ready = 1'b1;

  audio_snapshot_drain_if bus8();
  audio_snapshot_drain_if bus16();

  assign bus8.audio_valid_in  = audio_valid;
  assign bus8.audio_in        = audio;
  assign bus8.trigger_in      = trig8;
  assign bus8.drain_ready_in  = ready;
  assign bus16.audio_valid_in = audio_valid;
  assign bus16.audio_in       = audio;
  assign bus16.trigger_in     = trig16;
  assign bus16.drain_ready_in = ready;

  audio_snapshot_drain #(.SNAP_LEN(8),  .ADDR_WIDTH(3)) dut8  (.clk_in(clk_in), .rst_in(rst_in), .bus(bus8));
  audio_snapshot_drain #(.SNAP_LEN(16), .ADDR_WIDTH(4)) dut16 (.clk_in(clk_in), .rst_in(rst_in), .bus(bus16));

  typedef struct {logic [15:0] data; logic last;} exp_t;
  exp_t exp8[$];
  exp_t exp16[$];

  int vectors = 0;
  int fails   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic get_busy(input bit big);
    return big ? bus16.busy_out : bus8.busy_out;
  endfunction

  function automatic logic get_valid(input bit big);
    return big ? bus16.drain_valid_out : bus8.drain_valid_out;
  endfunction

  function automatic logic get_done(input bit big);
    return big ? bus16.done_out : bus8.done_out;
  endfunction

  task automatic set_trig(input bit big, input logic v);
    if (big) trig16 = v;
    else     trig8  = v;
  endtask

  // Trigger, then strobe n samples base, base+1, ... spaced 5 cycles apart.
  // Returns right after the last strobe edge (first DRAIN cycle) or early at stop_after.
  task automatic capture(input bit big, input logic [15:0] base, input int n,
                         input int stop_after, input int retrig_at, input bit junk);
    exp_t e;
    tick;
    set_trig(big, 1'b1);
    if (junk) begin audio_valid = 1'b1; audio = 16'hAAAA; end
    tick;
    set_trig(big, 1'b0);
    audio_valid = 1'b0;
    @(negedge clk_in);
    check(big ? "busy_after_trig16" : "busy_after_trig8", 32'(get_busy(big)), 32'd1);
    for (int i = 0; i < n; i++) begin
      if (i == stop_after) return;
      tick;
      audio_valid = 1'b1;
      audio       = base + 16'(i);
      e.data = base + 16'(i);
      e.last = (i == n - 1);
      if (big) exp16.push_back(e);
      else     exp8.push_back(e);
      tick;
      audio_valid = 1'b0;
      if (i < n - 1) begin
        tick;
        if (i == retrig_at) set_trig(big, 1'b1);
        tick;
        set_trig(big, 1'b0);
        tick;
      end
    end
  endtask

  // Follows a drain until done plus a few idle cycles; optionally stalls with a
  // fixed toggle pattern and/or injects triggers and strobes while draining.
  task automatic wait_drain(input bit big, input int n, input bit full_rate, input bit noise);
    int first = -1, lastv = -1, nval = 0, done_at = -1, done_cnt = 0;
    logic [31:0] pat = 32'hB2D3_965C;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk_in);
      if (get_valid(big)) begin
        nval++;
        if (first < 0) first = c;
        lastv = c;
      end
      if (get_done(big)) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
        check("busy_in_done", 32'(get_busy(big)), 32'd0);
        check("valid_in_done", 32'(get_valid(big)), 32'd0);
      end
      if (done_at >= 0 && c >= done_at + 3) break;
      tick;
      if (!full_rate) begin
        ready = pat[0];
        pat   = {pat[0], pat[31:1]};
      end
      if (noise && c < 6) begin
        set_trig(big, c[0]);
        audio_valid = ~c[0];
        audio       = 16'hDEAD;
      end else if (noise) begin
        set_trig(big, 1'b0);
        audio_valid = 1'b0;
      end
    end
    ready = 1'b1;
    if (done_at < 0) check("done_timeout", 32'd0, 32'd1);
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("done_after_last", 32'(done_at), 32'(lastv + 1));
    if (full_rate) begin
      check("first_valid_latency_ok", 32'(first <= 4), 32'd1);
      check("valid_cycles", 32'(nval), 32'(n));
      check("no_bubbles", 32'(lastv - first), 32'(n - 1));
    end
    check("left_undrained", 32'(big ? exp16.size() : exp8.size()), 32'd0);
    check("busy_after_drain", 32'(get_busy(big)), 32'd0);
  endtask

  // Monitor for the 8-sample instance.
  logic st8 = 1'b0, pl8 = 1'b0;
  logic [15:0] pd8 = 16'h0;
  always @(negedge clk_in) begin
    exp_t e;
    if (rst_in) st8 <= 1'b0;
    else begin
      if (bus8.drain_valid_out) begin
        if (st8) check("stall_hold8", 32'({bus8.drain_last_out, bus8.drain_data_out}), 32'({pl8, pd8}));
        if (bus8.drain_ready_in) begin
          if (exp8.size() == 0) check("extra_word8", 32'(bus8.drain_valid_out), 32'd0);
          else begin
            e = exp8.pop_front();
            check("drain8", 32'({bus8.drain_last_out, bus8.drain_data_out}), 32'({e.last, e.data}));
          end
        end
      end
      st8 <= bus8.drain_valid_out && !bus8.drain_ready_in;
      pd8 <= bus8.drain_data_out;
      pl8 <= bus8.drain_last_out;
    end
  end

  // Monitor for the 16-sample instance.
  logic st16 = 1'b0, pl16 = 1'b0;
  logic [15:0] pd16 = 16'h0;
  always @(negedge clk_in) begin
    exp_t e;
    if (rst_in) st16 <= 1'b0;
    else begin
      if (bus16.drain_valid_out) begin
        if (st16) check("stall_hold16", 32'({bus16.drain_last_out, bus16.drain_data_out}), 32'({pl16, pd16}));
        if (bus16.drain_ready_in) begin
          if (exp16.size() == 0) check("extra_word16", 32'(bus16.drain_valid_out), 32'd0);
          else begin
            e = exp16.pop_front();
            check("drain16", 32'({bus16.drain_last_out, bus16.drain_data_out}), 32'({e.last, e.data}));
          end
        end
      end
      st16 <= bus16.drain_valid_out && !bus16.drain_ready_in;
      pd16 <= bus16.drain_data_out;
      pl16 <= bus16.drain_last_out;
    end
  end

  task automatic check_quiet(input string name);
    check(name, 32'({bus8.busy_out, bus8.drain_valid_out, bus8.drain_last_out, bus8.done_out}), 32'd0);
    check(name, 32'(bus8.drain_data_out), 32'd0);
    check(name, 32'({bus16.busy_out, bus16.drain_valid_out, bus16.drain_last_out, bus16.done_out}), 32'd0);
    check(name, 32'(bus16.drain_data_out), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check_quiet("reset_outputs");
    tick;
    rst_in = 1'b0;

    // Full-rate drain of 0x0001..0x0008.
    capture(1'b0, 16'h0001, 8, -1, -1, 1'b0);
    wait_drain(1'b0, 8, 1'b1, 1'b0);

    // Same capture with a stalling consumer.
    capture(1'b0, 16'h0001, 8, -1, -1, 1'b0);
    wait_drain(1'b0, 8, 1'b0, 1'b0);

    // Strobe in the trigger cycle must not be stored.
    capture(1'b0, 16'h0010, 8, -1, -1, 1'b1);
    wait_drain(1'b0, 8, 1'b1, 1'b0);

    // Retrigger during CAPTURE and DRAIN plus strobes during DRAIN.
    capture(1'b0, 16'h0040, 8, -1, 3, 1'b0);
    wait_drain(1'b0, 8, 1'b1, 1'b1);

    // Reset after 4 of 8 samples, then a clean capture.
    capture(1'b0, 16'h0080, 8, 4, -1, 1'b0);
    tick;
    rst_in = 1'b1;
    exp8.delete();
    tick;
    rst_in = 1'b0;
    @(negedge clk_in);
    check_quiet("mid_capture_reset");
    capture(1'b0, 16'h0100, 8, -1, -1, 1'b0);
    wait_drain(1'b0, 8, 1'b1, 1'b0);

    // Full address space instance, with and without stalls.
    capture(1'b1, 16'h2000, 16, -1, -1, 1'b0);
    wait_drain(1'b1, 16, 1'b1, 1'b0);
    capture(1'b1, 16'h3000, 16, -1, -1, 1'b0);
    wait_drain(1'b1, 16, 1'b0, 1'b0);

    repeat (3) tick;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/audio_snapshot_drain.md
Name: audio_snapshot_drain

Overview:
- Captures a fixed-length window of 16-bit audio samples into on-chip block RAM when triggered.
- Then streams the window out in order over a valid/ready interface to a slower consumer, such as a debug UART or host link.
- It is the read-out side of the team's audio buffering: the delay line writes and replays in real time; this block freezes a window and hands it to a consumer that can stall.
- Sits on the 48 kHz sample-strobe domain beside the delay/echo path, sharing clk_in.

Parameters:
- SNAP_LEN, 4096: samples per snapshot; legal range 2..65536.
- ADDR_WIDTH, 12: RAM address width; must satisfy 2^ADDR_WIDTH >= SNAP_LEN.

Ports:
- clk_in  input  1  system clock; the single clock for the block.
- rst_in  input  1  synchronous, active-high reset.
- audio_valid_in  input  1  one-cycle sample strobe.
- audio_in  input  16  signed PCM sample; qualified by audio_valid_in.
- trigger_in  input  1  start-capture request; sampled every cycle.
- drain_ready_in  input  1  consumer can accept a word this cycle.
- drain_valid_out  output  1  drain_data_out holds a valid sample.
- drain_data_out  output  16  snapshot sample.
- drain_last_out  output  1  high with the final sample (index SNAP_LEN-1).
- busy_out  output  1  high in CAPTURE or DRAIN.
- done_out  output  1  one-cycle pulse after the last sample handshakes.

Behaviour:
- Reset: all outputs are 0, state is IDLE, and write/read counters are 0. RAM contents are don't-care.
- Reset mid-operation: on the next edge the block is in IDLE with all outputs 0. The partial snapshot is discarded, and a later trigger restarts from index 0.
- States: IDLE, CAPTURE, DRAIN.
- IDLE:
  - trigger_in=1 -> CAPTURE on the next edge.
  - An audio_valid_in in the trigger cycle itself is NOT stored.
- CAPTURE:
  - Each audio_valid_in=1 cycle writes audio_in to address wr_cnt, then wr_cnt increments.
  - The write that makes wr_cnt reach SNAP_LEN moves the block to DRAIN on the same edge.
  - Cycles without audio_valid_in store nothing.
  - No wrap: exactly SNAP_LEN samples are stored at addresses 0..SNAP_LEN-1.
- DRAIN:
  - RAM reads are synchronous with 2-cycle read latency (output register enabled).
  - A prefetch/skid buffer of depth ≥3 hides this latency.
  - The first drain_valid_out rises no later than 4 cycles after entering DRAIN.
  - A handshake occurs on an edge where drain_valid_out && drain_ready_in.
  - While drain_valid_out=1 && drain_ready_in=0, drain_data_out and drain_last_out hold stable and drain_valid_out stays 1.
  - With drain_ready_in held at 1, throughput is one sample per cycle, with no bubbles after the first word.
  - Samples come out in capture order, index 0..SNAP_LEN-1. No duplicates, no drops.
  - drain_last_out is 1 only alongside index SNAP_LEN-1.
  - On the last handshake: next cycle the state is IDLE, done_out=1 for exactly one cycle, and drain_valid_out=0.
- busy_out is 1 exactly while the state is CAPTURE or DRAIN.
- trigger_in is ignored in CAPTURE and DRAIN; it is not queued.
- trigger_in high in the done_out cycle (already IDLE) starts a new capture.
- audio_valid_in during DRAIN or IDLE is ignored.
- drain_ready_in may toggle arbitrarily, including while drain_valid_out=0; it has no effect outside DRAIN.
- Widths:
  - wr_cnt and rd_cnt are ADDR_WIDTH+1 bits, so the count SNAP_LEN is representable when SNAP_LEN = 2^ADDR_WIDTH.
  - Data passes through unmodified; no arithmetic on samples.

Test Plan:
- SNAP_LEN=8; trigger, then 8 strobes with audio_in = 0x0001..0x0008 spaced 5 cycles apart; drain_ready_in=1 -> busy_out high from the cycle after trigger. Drain emits 0x0001..0x0008 on 8 consecutive cycles, drain_last_out with 0x0008, then one done_out pulse and busy_out=0.
- Same capture; drain_ready_in toggles in pseudo-random 1/0 pattern -> every stalled word stays stable; exactly 8 handshakes in order 0x0001..0x0008; no extra valid after last.
- audio_valid_in=1 with audio_in=0xAAAA in the trigger cycle, then samples 0x0010..0x0017 -> 0xAAAA is absent and the first drained word is 0x0010.
- Second trigger during CAPTURE and during DRAIN, plus audio strobes during DRAIN -> no restart, drained data unchanged.
- rst_in asserted after 4 of 8 samples are captured -> next cycle all outputs 0 and state IDLE. A new trigger plus 8 samples 0x0100..0x0107 drains exactly those values.
- SNAP_LEN=16, ADDR_WIDTH=4 (full address space) -> all 16 samples drain correctly, with drain_last_out on index 15 and no wrap to index 0.
